// File: rtl/gate_param_if.sv
// Stream and parameter-bus bundle between a word source, gate_param_loader and the LSTM gate layer.
// master drives the stream and the acknowledge; slave is the loader.
interface gate_param_if #(
  parameter int dataWidth    = 5,
  parameter int hiddenSize1  = 3,
  parameter int hiddenSize2  = 3,
  parameter int reWeightSize = 9
);
  logic [dataWidth-1:0]              inData;
  logic                              inValid;
  logic                              inReady;
  logic                              hidOnly;
  logic                              paramAck;
  logic [dataWidth*reWeightSize-1:0] ReW;
  logic [dataWidth*hiddenSize1-1:0]  b;
  logic [dataWidth*hiddenSize2-1:0]  hid;
  logic                              paramValid;
  logic                              frameErr;

  modport master (
    output inData, inValid, hidOnly, paramAck,
    input  inReady, ReW, b, hid, paramValid, frameErr
  );

  modport slave (
    input  inData, inValid, hidOnly, paramAck,
    output inReady, ReW, b, hid, paramValid, frameErr
  );
endinterface

// File: rtl/gate_param_loader.sv
// Serial-to-parallel loader for one LSTM gate layer: ReW, b and hid are assembled from a word stream.
// Optional trailing checksum word per frame is enabled by defining GATE_LOADER_CHECKSUM_EN.
module gate_param_loader #(
  parameter int dataWidth    = 5,
  parameter int hiddenSize1  = 3,
  parameter int hiddenSize2  = 3,
  parameter int reWeightSize = 9
) (
  input logic         clk,
  input logic         rst,
  gate_param_if.slave bus
);
  localparam int CW = (reWeightSize > 1) ? $clog2(reWeightSize) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] W_LAST   = CW'(reWeightSize - 1);
  localparam logic [CW-1:0] B_LAST   = CW'(hiddenSize1 - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(hiddenSize2 - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    LOAD_H = 3'd3,
`ifdef GATE_LOADER_CHECKSUM_EN
    CHK    = 3'd5,
`endif
    HOLD   = 3'd4
  } state_t;

  state_t                            state_r, state_nx_s, seg_s;
  logic [CW-1:0]                     cnt_r, cnt_nx_s;
  logic                              wloaded_r, wloaded_nx_s;
  logic                              full_r, full_nx_s;
  logic                              ready_s, accept_s;
  logic                              wr_w_s, wr_b_s, wr_h_s;
  logic                              pvalid_r;
  logic [dataWidth*reWeightSize-1:0] rew_r;
  logic [dataWidth*hiddenSize1-1:0]  b_r;
  logic [dataWidth*hiddenSize2-1:0]  hid_r;

`ifdef GATE_LOADER_CHECKSUM_EN
  logic [dataWidth-1:0] sum_r, sum_nx_s;
  logic                 ferr_r, ferr_nx_s;

  // Running modulo-2^dataWidth sum of the frame's data words.
  function automatic logic [dataWidth-1:0] csum_add(input logic [dataWidth-1:0] acc,
                                                    input logic [dataWidth-1:0] word);
    return acc + word;
  endfunction
`endif

  // Handshake: ready everywhere except HOLD and while reset is asserted.
  always_comb begin
    ready_s  = (!rst) && (state_r != HOLD);
    accept_s = ready_s && bus.inValid;
  end

  // Next-state, counter, frame-type and bus write-enable decode.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    wloaded_nx_s = wloaded_r;
    full_nx_s    = full_r;
    wr_w_s       = 1'b0;
    wr_b_s       = 1'b0;
    wr_h_s       = 1'b0;
`ifdef GATE_LOADER_CHECKSUM_EN
    sum_nx_s     = sum_r;
    ferr_nx_s    = 1'b0;
`endif
    // The first word of a frame is handled as word 0 of the segment it opens.
    if (state_r == IDLE) begin
      seg_s = (bus.hidOnly && wloaded_r) ? LOAD_H : LOAD_W;
    end else begin
      seg_s = state_r;
    end

    if (state_r == HOLD) begin
      if (bus.paramAck) begin
        state_nx_s = IDLE;
      end else begin
        state_nx_s = HOLD;
      end
    end else if (accept_s) begin
      if (state_r == IDLE) begin
        full_nx_s = (seg_s == LOAD_W);
`ifdef GATE_LOADER_CHECKSUM_EN
        sum_nx_s  = bus.inData;
      end else begin
        sum_nx_s  = csum_add(sum_r, bus.inData);
`endif
      end else begin
        full_nx_s = full_r;
      end

      case (seg_s)
        LOAD_W: begin
          wr_w_s = 1'b1;
          if (cnt_r == W_LAST) begin
            cnt_nx_s   = CNT_ZERO;
            state_nx_s = LOAD_B;
          end else begin
            cnt_nx_s   = cnt_r + CNT_ONE;
            state_nx_s = LOAD_W;
          end
        end
        LOAD_B: begin
          wr_b_s = 1'b1;
          if (cnt_r == B_LAST) begin
            cnt_nx_s   = CNT_ZERO;
            state_nx_s = LOAD_H;
          end else begin
            cnt_nx_s   = cnt_r + CNT_ONE;
            state_nx_s = LOAD_B;
          end
        end
        LOAD_H: begin
          wr_h_s = 1'b1;
          if (cnt_r == H_LAST) begin
            cnt_nx_s = CNT_ZERO;
`ifdef GATE_LOADER_CHECKSUM_EN
            state_nx_s = CHK;
`else
            state_nx_s = HOLD;
            if (full_nx_s) begin
              wloaded_nx_s = 1'b1;
            end else begin
              wloaded_nx_s = wloaded_r;
            end
`endif
          end else begin
            cnt_nx_s   = cnt_r + CNT_ONE;
            state_nx_s = LOAD_H;
          end
        end
`ifdef GATE_LOADER_CHECKSUM_EN
        CHK: begin
          if (bus.inData == sum_r) begin
            state_nx_s = HOLD;
            if (full_r) begin
              wloaded_nx_s = 1'b1;
            end else begin
              wloaded_nx_s = wloaded_r;
            end
          end else begin
            // A failed full frame may have overwritten ReW/b, so hidden-only frames are refused.
            state_nx_s = IDLE;
            ferr_nx_s  = 1'b1;
            if (full_r) begin
              wloaded_nx_s = 1'b0;
            end else begin
              wloaded_nx_s = wloaded_r;
            end
          end
        end
`endif
        default: begin
          state_nx_s = IDLE;
          cnt_nx_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      wloaded_r <= 1'b0;
      full_r    <= 1'b0;
      pvalid_r  <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      wloaded_r <= wloaded_nx_s;
      full_r    <= full_nx_s;
      pvalid_r  <= (state_nx_s == HOLD);
    end
  end

  // Parameter buses, written in place one word per accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rew_r <= '0;
      b_r   <= '0;
      hid_r <= '0;
    end else begin
      for (int k = 0; k < reWeightSize; k++) begin
        if (wr_w_s && (cnt_r == CW'(k))) rew_r[dataWidth*k +: dataWidth] <= bus.inData;
      end
      for (int k = 0; k < hiddenSize1; k++) begin
        if (wr_b_s && (cnt_r == CW'(k))) b_r[dataWidth*k +: dataWidth] <= bus.inData;
      end
      for (int k = 0; k < hiddenSize2; k++) begin
        if (wr_h_s && (cnt_r == CW'(k))) hid_r[dataWidth*k +: dataWidth] <= bus.inData;
      end
    end
  end

`ifdef GATE_LOADER_CHECKSUM_EN
  // Checksum accumulator and one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r  <= '0;
      ferr_r <= 1'b0;
    end else begin
      sum_r  <= sum_nx_s;
      ferr_r <= ferr_nx_s;
    end
  end

  assign bus.frameErr = ferr_r;
`else
  assign bus.frameErr = 1'b0;
`endif

  assign bus.inReady    = ready_s;
  assign bus.paramValid = pvalid_r;
  assign bus.ReW        = rew_r;
  assign bus.b          = b_r;
  assign bus.hid        = hid_r;
endmodule

// File: doc/gate_param_loader.md
# gate_param_loader

Serial-to-parallel parameter loader that feeds one LSTM gate layer. It accepts a stream of fixed-point words over a valid/ready handshake and assembles the flat `ReW`, `b` and `hid` buses that the gate layer consumes. It then holds those buses stable behind `paramValid` until the gate layer acknowledges. Weights and bias persist across timesteps, so each later timestep needs only a short hidden-state frame.

## Interface
- `dataWidth`, 5, width of one fixed-point word
- `hiddenSize1`, 3, number of gate neurons; sets the bias word count
- `hiddenSize2`, 3, hidden-vector length; sets the hidden word count
- `reWeightSize`, 9, recurrent weight word count; must equal `hiddenSize1*hiddenSize2`
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `inData`  in  dataWidth  stream word
- `inValid`  in  1  `inData` is valid
- `inReady`  out  1  loader accepts a word this cycle
- `hidOnly`  in  1  frame type; sampled only on the first accepted word of a frame
- `paramAck`  in  1  consumer has finished with the current parameters
- `ReW`  out  dataWidth*reWeightSize  recurrent weights; word k at `[dataWidth*k +: dataWidth]`
- `b`  out  dataWidth*hiddenSize1  bias; word k at `[dataWidth*k +: dataWidth]`
- `hid`  out  dataWidth*hiddenSize2  hidden state; word k at `[dataWidth*k +: dataWidth]`
- `paramValid`  out  1  buses are complete and stable
- `frameErr`  out  1  one-cycle checksum-failure pulse

## Operation
- Transfer rule: a word is accepted on any rising edge where `inValid` and `inReady` are both high.
- States:
  - IDLE
  - LOAD_W
  - LOAD_B
  - LOAD_H
  - CHK (only when the checksum macro is defined)
  - HOLD
- `inReady` is 1 in IDLE, LOAD_* and CHK. It is 0 in HOLD and on any cycle where `rst` is high.
- First word accepted in IDLE:
  - Full frame (`hidOnly`=0): the word is written to `ReW[0]` and the state goes to LOAD_W.
  - Hidden-only frame (`hidOnly`=1 and `wLoaded`=1): the word is written to `hid[0]` and the state goes to LOAD_H.
  - `hidOnly`=1 with `wLoaded`=0 is treated as a full frame.
- Full-frame word order: ReW 0..reWeightSize-1, then b 0..hiddenSize1-1, then hid 0..hiddenSize2-1.
- Word counter:
  - A single counter of width `$clog2(reWeightSize)` indexes the current segment.
  - It clears on each segment transition: LOAD_W→LOAD_B after word reWeightSize-1, LOAD_B→LOAD_H after word hiddenSize1-1.
  - After the last hid word the state goes to HOLD, or to CHK when the checksum is enabled.
- Hidden-only frames leave `ReW` and `b` untouched.
- Buses are written in place as words arrive. Their values are meaningful only while `paramValid`=1.
- Internal flag `wLoaded`:
  - Set when a full frame completes successfully.
  - Cleared by reset and by a failed full frame.
- HOLD:
  - `paramValid`=1, and buses are frozen.
  - `paramAck`=1 moves the state to IDLE.
  - `paramAck` in any other state is ignored.
- `rst` in any state, including mid-frame:
  - Next state is IDLE, counter 0, `wLoaded`=0.
  - All outputs go to 0: `ReW`, `b`, `hid`, `paramValid`, `frameErr`.
  - Partially received words are discarded.

## Timing
- `paramValid` rises the cycle after the final word is accepted (registered). With `inValid` held high, a full frame takes reWeightSize+hiddenSize1+hiddenSize2 accept cycles, and `paramValid` rises one cycle later.
- `paramValid` falls the cycle after `paramAck` is sampled high. `inReady` rises in that same cycle.
- `inValid` gaps stall the loader without losing position. No timeout.
- Each bus word updates one cycle after its accept edge.
- `frameErr` is high for exactly one cycle, the cycle after the checksum word is accepted.

## Configuration
- Macro: `GATE_LOADER_CHECKSUM_EN`.
- Defined:
  - Every frame carries one trailing checksum word, equal to the sum of all frame data words modulo 2^dataWidth.
  - On a match: state goes to HOLD and `paramValid` rises.
  - On a mismatch: `frameErr` pulses, the state goes to IDLE, and `paramValid` stays 0. A failed full frame also clears `wLoaded`.
- Not defined: there is no CHK state and no checksum word, and `frameErr` is tied to 0.

## Test plan
- Reset then full frame, words 1..15 with `inValid` held high → `ReW` words = 1..9, `b` = 10,11,12, `hid` = 13,14,15. `paramValid` rises 1 cycle after word 15 is accepted; `inReady`=0 in HOLD.
- Same full frame with `inValid` low every other cycle → identical bus contents. `paramValid` rises 1 cycle after the last accept.
- HOLD with `inValid`=1 for 5 cycles → no word accepted and buses unchanged. `paramAck` pulse → `paramValid`=0 next cycle. Then a hidden-only frame 7,8,9 → `hid`=7,8,9, with `ReW`/`b` unchanged.
- After reset, `hidOnly`=1 with words 1..15 → treated as a full frame, giving the same result as the first scenario.
- `rst` asserted after 6 words of a full frame → all buses 0, `paramValid`=0, state IDLE. A following hidden-only frame is treated as a full frame.
- With `GATE_LOADER_CHECKSUM_EN`, full frame 1..15:
  - checksum 120 mod 32 = 24 → `paramValid`=1.
  - checksum 25 → `frameErr` pulses once, `paramValid` stays 0, and the next `hidOnly` frame loads as a full frame.
